// File: rtl/pmt_lower_com_pkg.sv
// Shared FFT permutation types: sample width, lane count, complex sample.
// No logic of its own; constants and one index helper.
// Imported by the transpose buffer and the top level.
package pmt_lower_com_pkg;

  // Default real/imaginary sample width
  localparam int PMT_DW   = 8;
  // Lanes per word, and words per block (the block is square)
  localparam int LANES    = 4;
  // Block-end marker delay; equals the data latency through the block
  localparam int CTRL_DLY = 5;

  // Complex sample at the default width
  typedef struct packed {
    logic [PMT_DW-1:0] re;
    logic [PMT_DW-1:0] im;
  } cplx_t;

  // The block-end word always lands in the last row, however early it comes
  function automatic logic [1:0] wr_index(input logic ctrl, input logic [1:0] cnt);
    return ctrl ? 2'd3 : cnt;
  endfunction

endpackage

// File: rtl/pmt_lower_com_tbuf.sv
// Ping-pong 4x4 complex transpose buffer with a registered read port.
// Latency: 1 cycle from read index to o_rd_dat.
// No backpressure; one row written and one transposed row read every cycle.
module pmt_tbuf
  import pmt_lower_com_pkg::*;
#(
  parameter type samp_t = cplx_t
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_bank,
  input  logic [1:0]              i_idx,
  input  samp_t [LANES-1:0]       i_wr_dat,
  output samp_t [LANES-1:0]       o_rd_dat
);

  // Storage indexed [bank][word][lane]
  samp_t r_bank [2][LANES][LANES];
  logic  w_rd_bank;

  // The bank not being written holds the previous, complete block
  assign w_rd_bank = ~i_wr_bank;

  // Write row i_idx of the write bank; read column i_idx of the read bank as a row
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < LANES; w++) begin
          for (int l = 0; l < LANES; l++) begin
            r_bank[b][w][l] <= '0;
          end
        end
      end
      o_rd_dat <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        r_bank[i_wr_bank][i_idx][l] <= i_wr_dat[l];
      end
      for (int i = 0; i < LANES; i++) begin
        o_rd_dat[i] <= r_bank[w_rd_bank][i][i_idx];
      end
    end
  end

endmodule

// File: rtl/pmt_lower_com.sv
// 4x4 complex block transpose (FFT lower permutation), 4 lanes per word.
// Latency: 5 cycles word-to-word; ctrl_out is ctrl_in delayed 5 cycles.
// No backpressure; streams one word per cycle with no bubbles.
module pmt_lower_com
  import pmt_lower_com_pkg::*;
#(
  parameter int DW = PMT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] x_a_in,
  input  logic [DW-1:0] y_a_in,
  input  logic [DW-1:0] x_b_in,
  input  logic [DW-1:0] y_b_in,
  input  logic [DW-1:0] x_c_in,
  input  logic [DW-1:0] y_c_in,
  input  logic [DW-1:0] x_d_in,
  input  logic [DW-1:0] y_d_in,
  input  logic          ctrl_in,
  output logic [DW-1:0] x_a_out,
  output logic [DW-1:0] y_a_out,
  output logic [DW-1:0] x_b_out,
  output logic [DW-1:0] y_b_out,
  output logic [DW-1:0] x_c_out,
  output logic [DW-1:0] y_c_out,
  output logic [DW-1:0] x_d_out,
  output logic [DW-1:0] y_d_out,
  output logic          ctrl_out
);

  // Same layout as cplx_t, sized by this instance's DW
  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } samp_t;

  logic [1:0]          r_cnt;
  logic                r_wr_bank;
  logic [CTRL_DLY-1:0] r_ctrl_dly;
  logic [1:0]          w_idx;
  samp_t [LANES-1:0]   w_wr_dat;
  samp_t [LANES-1:0]   w_rd_dat;

  // Write and read share one index: the read of the old block runs in step
  // with the fill of the new one, so row j comes out one cycle after word j
  // of the next block is written
  assign w_idx = wr_index(ctrl_in, r_cnt);

  assign w_wr_dat[0] = '{re: x_a_in, im: y_a_in};
  assign w_wr_dat[1] = '{re: x_b_in, im: y_b_in};
  assign w_wr_dat[2] = '{re: x_c_in, im: y_c_in};
  assign w_wr_dat[3] = '{re: x_d_in, im: y_d_in};

  // Word counter, bank select and block-end delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 2'd0;
      r_wr_bank  <= 1'b0;
      r_ctrl_dly <= '0;
    end else begin
      r_cnt      <= ctrl_in ? 2'd0 : r_cnt + 2'd1;
      r_wr_bank  <= ctrl_in ? ~r_wr_bank : r_wr_bank;
      r_ctrl_dly <= {r_ctrl_dly[CTRL_DLY-2:0], ctrl_in};
    end
  end

  pmt_tbuf #(
    .samp_t (samp_t)
  ) u_tbuf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_bank (r_wr_bank),
    .i_idx     (w_idx),
    .i_wr_dat  (w_wr_dat),
    .o_rd_dat  (w_rd_dat)
  );

  assign x_a_out  = w_rd_dat[0].re;
  assign y_a_out  = w_rd_dat[0].im;
  assign x_b_out  = w_rd_dat[1].re;
  assign y_b_out  = w_rd_dat[1].im;
  assign x_c_out  = w_rd_dat[2].re;
  assign y_c_out  = w_rd_dat[2].im;
  assign x_d_out  = w_rd_dat[3].re;
  assign y_d_out  = w_rd_dat[3].im;
  assign ctrl_out = r_ctrl_dly[CTRL_DLY-1];

endmodule

// File: tb/tb_pmt_lower_com.sv
// Scoreboard bench for pmt_lower_com: stimulus queues expected rows keyed by
// the cycle they must appear in; a monitor on the falling edge pops and
// compares them against the outputs.
module tb_pmt_lower_com;

  localparam int DW = 8;

  typedef logic [3:0][DW-1:0] row_t;
  typedef logic [3:0][3:0][DW-1:0] blk_t;  // [word][lane]

  typedef struct {
    int    c;
    row_t  x;
    row_t  y;
    logic  ctrl;
    string tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ctrl_in = 1'b0;
  logic [DW-1:0] xi [4];
  logic [DW-1:0] yi [4];
  logic [DW-1:0] xo [4];
  logic [DW-1:0] yo [4];
  logic          ctrl_out;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pmt_lower_com #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .x_a_in   (xi[0]), .y_a_in (yi[0]),
    .x_b_in   (xi[1]), .y_b_in (yi[1]),
    .x_c_in   (xi[2]), .y_c_in (yi[2]),
    .x_d_in   (xi[3]), .y_d_in (yi[3]),
    .ctrl_in  (ctrl_in),
    .x_a_out  (xo[0]), .y_a_out (yo[0]),
    .x_b_out  (xo[1]), .y_b_out (yo[1]),
    .x_c_out  (xo[2]), .y_c_out (yo[2]),
    .x_d_out  (xo[3]), .y_d_out (yo[3]),
    .ctrl_out (ctrl_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Block with x[w][k] = base + 4w + k + 1
  function automatic blk_t mk_blk(input int base);
    blk_t b;
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++)
        b[w][k] = DW'(base + 4 * w + k + 1);
    return b;
  endfunction

  // Keep the scoreboard ordered by due cycle
  task automatic push_exp(input int c, input row_t x, input row_t y, input logic ctrl, input string tag);
    exp_t e;
    int   pos;
    e.c = c; e.x = x; e.y = y; e.ctrl = ctrl; e.tag = tag;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].c > c) pos--;
    sb.insert(pos, e);
  endtask

  task automatic drive(input logic r, input logic c, input row_t x, input row_t y);
    @(negedge clk);
    rst = r;
    ctrl_in = c;
    for (int k = 0; k < 4; k++) begin
      xi[k] = x[k];
      yi[k] = y[k];
    end
  endtask

  // Four words, ctrl on the last; the first n_chk transposed rows are expected 5 cycles on
  task automatic send_block(input blk_t xb, input blk_t yb, input int n_chk, input string tag);
    row_t tx, ty;
    for (int w = 0; w < 4; w++) begin
      drive(1'b0, (w == 3), xb[w], yb[w]);
      if (w < n_chk) begin
        for (int i = 0; i < 4; i++) begin
          tx[i] = xb[i][w];
          ty[i] = yb[i][w];
        end
        push_exp(cyc + 5, tx, ty, (w == 3), tag);
      end
    end
  endtask

  // Monitor: compare every entry due this cycle; a stale entry is a miss
  initial begin
    exp_t e;
    row_t ax, ay;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].c <= cyc) begin
        e = sb.pop_front();
        checks++;
        for (int i = 0; i < 4; i++) begin
          ax[i] = xo[i];
          ay[i] = yo[i];
        end
        if (e.c < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not compared (now %0d)", e.tag, e.c, cyc);
        end else if (ax !== e.x || ay !== e.y || ctrl_out !== e.ctrl) begin
          errors++;
          $display("FAIL %s @%0d: got x=%h y=%h ctrl=%b, want x=%h y=%h ctrl=%b",
                   e.tag, cyc, ax, ay, ctrl_out, e.x, e.y, e.ctrl);
        end
      end
    end
  end

  // Guard against a run that never ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    row_t zr, rx, ry;
    blk_t blk_a, blk_a_y100, blk_b, blk_b_y, blk_z;
    row_t q0x, q0y, q1x, q1y;
    int   q;

    zr = '0;
    blk_z = '0;
    blk_a = mk_blk(0);
    blk_a_y100 = mk_blk(100);
    blk_b = mk_blk(20);
    blk_b_y = mk_blk(120);
    for (int k = 0; k < 4; k++) begin
      xi[k] = '0;
      yi[k] = '0;
    end

    // Reset held 20 cycles, then 5 cycles of nonzero data with no block end
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 4; k++) begin rx[k] = DW'(n * 7 + k + 3); ry[k] = DW'(n * 5 + k + 9); end
      drive(1'b1, 1'b0, rx, ry);
      push_exp(cyc + 1, zr, zr, 1'b0, "rst_hold");
    end
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 4; k++) begin rx[k] = DW'(n + 4 * k + 1); ry[k] = DW'(n + 4 * k + 2); end
      drive(1'b0, 1'b0, rx, ry);
      push_exp(cyc + 1, zr, zr, 1'b0, "post_rst");
    end

    // Sync word, then the basic block and 16 back-to-back repeats
    drive(1'b0, 1'b1, zr, zr);
    send_block(blk_a, blk_z, 4, "basic");
    for (int b = 0; b < 16; b++) send_block(blk_a, blk_z, 4, "stream");

    // Distinct imaginary parts
    send_block(blk_a, blk_a_y100, 4, "y_indep_a");
    send_block(blk_b, blk_a_y100, 4, "y_indep_b");

    // Let the last block drain, then reset two words into a new block
    for (int n = 0; n < 4; n++) drive(1'b0, 1'b0, zr, zr);
    drive(1'b0, 1'b0, blk_a[0], blk_a[0]);
    drive(1'b0, 1'b0, blk_a[1], blk_a[1]);
    drive(1'b1, 1'b0, blk_a[2], blk_a[2]);
    for (int n = 1; n <= 5; n++) push_exp(cyc + n, zr, zr, 1'b0, "mid_rst");
    send_block(blk_b, blk_b_y, 4, "after_rst");

    // Early block end: P (only row 0 emitted before the swap), then Q of 2 words
    send_block(blk_a, blk_z, 1, "pre_early");
    for (int k = 0; k < 4; k++) begin
      q0x[k] = DW'(50 + k); q0y[k] = DW'(150 + k);
      q1x[k] = DW'(60 + k); q1y[k] = DW'(160 + k);
    end
    drive(1'b0, 1'b0, q0x, q0y);
    drive(1'b0, 1'b1, q1x, q1y);
    q = cyc;
    // Rows 1 and 2 of this bank still hold the post-reset block (x 25..32, y 125..132)
    for (int j = 0; j < 4; j++) begin
      rx[0] = DW'(50 + j); rx[1] = DW'(25 + j); rx[2] = DW'(29 + j); rx[3] = DW'(60 + j);
      ry[0] = DW'(150 + j); ry[1] = DW'(125 + j); ry[2] = DW'(129 + j); ry[3] = DW'(160 + j);
      push_exp(q + 2 + j, rx, ry, (j == 1 || j == 3), "early_ctrl");
    end
    send_block(blk_b, blk_a_y100, 4, "after_early");

    for (int n = 0; n < 10; n++) drive(1'b0, 1'b0, zr, zr);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never compared, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
